// File: rtl/up_job_sequencer_if.sv
// Job / result / microprocessor signal bundle for up_job_sequencer.
// Handshakes: a transfer happens on a rising CLOCK edge where valid and ready
// are both high; the valid side holds its payload stable until that edge and
// never withdraws valid early; the ready side may raise or drop ready freely.
interface up_job_sequencer_if;
  logic       JobValid;
  logic [7:0] JobA;
  logic [7:0] JobB;
  logic       JobReady;
  logic       UpReset;
  logic       UpEnter;
  logic [7:0] UpInput;
  logic       UpHalt;
  logic [7:0] UpOutput;
  logic       ResValid;
  logic       ResReady;
  logic [7:0] ResData;
  logic       ResErr;
  logic       Busy;

  modport slave (
    input  JobValid, JobA, JobB, UpHalt, UpOutput, ResReady,
    output JobReady, UpReset, UpEnter, UpInput, ResValid, ResData, ResErr, Busy
  );

  modport master (
    output JobValid, JobA, JobB, UpHalt, UpOutput, ResReady,
    input  JobReady, UpReset, UpEnter, UpInput, ResValid, ResData, ResErr, Busy
  );
endinterface

// File: rtl/up_job_sequencer.sv
// Feeds two operands to a microprocessor through a reset / setup / strobe
// sequence, waits for it to halt (with a timeout) and returns its result.
module up_job_sequencer #(
  parameter int SETUP_CYC = 5,
  parameter int ENTER_CYC = 2,
  parameter int GAP_CYC   = 15,
  parameter int TIMEOUT   = 4095
) (
  input  logic                CLOCK,
  input  logic                RESET_N,
  up_job_sequencer_if.slave   bus,
  output logic [3:0]          dbg_state_o
);

  typedef enum logic [3:0] {
    IDLE, RST_UP, SETUP_A, ENTER_A, GAP, SETUP_B, ENTER_B, WAIT_HALT, RESULT
  } state_t;

  // Each phase counter starts at 0 on state entry and leaves at its "last" value.
  localparam logic [11:0] SETUP_LAST = 12'(SETUP_CYC - 1);
  localparam logic [11:0] ENTER_LAST = 12'(ENTER_CYC - 1);
  localparam logic [11:0] GAP_LAST   = 12'(GAP_CYC - 1);
  localparam logic [11:0] TOUT_LAST  = 12'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  data_q, data_d;
  logic        err_q, err_d;
  logic        jr_q, jr_d;
  logic        upr_q, upr_d;
  logic        tout;

  // State, counter, operand and result registers.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= 12'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      data_q  <= 8'd0;
      err_q   <= 1'b0;
      jr_q    <= 1'b0;
      upr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
      jr_q    <= jr_d;
      upr_q   <= upr_d;
    end
  end

  // Next-state, phase counting and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 12'd1;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    err_d   = err_q;
    tout    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.JobValid && jr_q) begin
          a_d = bus.JobA;
          b_d = bus.JobB;
          if (bus.JobA == 8'd0 || bus.JobB == 8'd0) begin
            // A zero operand is rejected without touching the microprocessor.
            state_d = RESULT;
            data_d  = 8'd0;
            err_d   = 1'b1;
          end else begin
            state_d = RST_UP;
          end
        end
      end
      RST_UP:  state_d = SETUP_A;
      SETUP_A: if (cnt_q == SETUP_LAST) state_d = ENTER_A;
      ENTER_A: if (cnt_q == ENTER_LAST) state_d = GAP;
      GAP:     if (cnt_q == GAP_LAST)   state_d = SETUP_B;
      SETUP_B: if (cnt_q == SETUP_LAST) state_d = ENTER_B;
      ENTER_B: if (cnt_q == ENTER_LAST) state_d = WAIT_HALT;
      WAIT_HALT: begin
        // UpHalt is only looked at here, so a stale halt from a previous job is harmless.
        if (bus.UpHalt) begin
          state_d = RESULT;
          data_d  = bus.UpOutput;
          err_d   = 1'b0;
        end else if (cnt_q == TOUT_LAST) begin
          state_d = RESULT;
          data_d  = 8'd0;
          err_d   = 1'b1;
          tout    = 1'b1;
        end
      end
      RESULT:  if (bus.ResReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = 12'd0;
    jr_d  = (state_d == IDLE);
    upr_d = (state_d == RST_UP) || tout;
  end

  // Operand presented to the microprocessor for the current phase.
  always_comb begin
    bus.UpInput = 8'd0;
    case (state_q)
      SETUP_A, ENTER_A, GAP:      bus.UpInput = a_q;
      SETUP_B, ENTER_B, WAIT_HALT: bus.UpInput = b_q;
      default:                     bus.UpInput = 8'd0;
    endcase
  end

  assign bus.JobReady = jr_q;
  assign bus.UpReset  = upr_q;
  assign bus.UpEnter  = (state_q == ENTER_A) || (state_q == ENTER_B);
  assign bus.ResValid = (state_q == RESULT);
  assign bus.ResData  = data_q;
  assign bus.ResErr   = err_q;
  assign bus.Busy     = (state_q != IDLE);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_up_job_sequencer.sv
// Bench for up_job_sequencer: behavioural GCD microprocessor, fixed job table,
// randomized jobs and hand-written multi-cycle corner cases.
module tb_up_job_sequencer;

  localparam int SETUP_CYC = 5;
  localparam int ENTER_CYC = 2;
  localparam int GAP_CYC   = 15;
  localparam int TIMEOUT   = 4095;
  // Edges from the accepting edge to the sequence reaching WAIT_HALT.
  localparam int SEQ_CYC   = 1 + 2 * (SETUP_CYC + ENTER_CYC) + GAP_CYC;

  logic       CLOCK = 1'b0;
  logic       RESET_N;
  logic [3:0] dbg_state;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  up_job_sequencer_if bus();

  up_job_sequencer #(
    .SETUP_CYC(SETUP_CYC), .ENTER_CYC(ENTER_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .bus        (bus.slave),
    .dbg_state_o(dbg_state)
  );

  // Clock / cycle counter
  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc = cyc + 1;

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Latency counted in edges after the accepting edge until ResValid is seen.
  function automatic int ref_lat(input int a, input int b, input int d, input bit nohalt);
    if (a == 0 || b == 0) return 0;
    if (nohalt) return SEQ_CYC + TIMEOUT;
    return SEQ_CYC + 1 + d;
  endfunction

  // Behavioural microprocessor: records each UpEnter pulse, answers the GCD
  // of the two operands after halt_delay idle cycles and holds UpHalt until UpReset.
  int         halt_delay = 0;
  bit         halt_off   = 1'b0;
  bit         stale_halt = 1'b0;
  logic [7:0] op_log[1024];
  int         width_log[1024];
  int         n_rise = 0;

  initial begin
    int  got, cd, cur_w;
    bit  mhalt, prev_en;
    logic [7:0] res;
    got = 0; cd = 0; cur_w = 0; mhalt = 1'b0; prev_en = 1'b0; res = 8'd0;
    bus.UpHalt = 1'b0;
    bus.UpOutput = 8'd0;
    forever begin
      @(posedge CLOCK);
      #2;
      if (bus.UpReset) begin
        mhalt = 1'b0;
        cd = 0;
        got = 0;
      end else if (bus.UpEnter) begin
        if (!prev_en) begin
          op_log[n_rise] = bus.UpInput;
          got++;
          cur_w = 0;
        end
        cur_w++;
      end else if (prev_en) begin
        width_log[n_rise] = cur_w;
        n_rise++;
        if (got == 2 && !halt_off) begin
          res = 8'(ref_gcd(int'(op_log[n_rise-2]), int'(op_log[n_rise-1])));
          if (halt_delay == 0) mhalt = 1'b1;
          else cd = halt_delay;
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) mhalt = 1'b1;
      end
      prev_en = bus.UpEnter;
      bus.UpHalt = mhalt | stale_halt;
      bus.UpOutput = mhalt ? res : 8'd0;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  int acc_cyc;
  int base_rise;

  // Presents a job and waits for its acceptance; returns cycles spent waiting.
  task automatic send_job(input logic [7:0] a, input logic [7:0] b, output int waited);
    bit jr;
    bit done;
    bus.JobA = a;
    bus.JobB = b;
    bus.JobValid = 1'b1;
    base_rise = n_rise;
    done = 1'b0;
    waited = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      jr = bus.JobReady;
      step();
      waited++;
      if (jr) done = 1'b1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    acc_cyc = cyc;
    bus.JobValid = 1'b0;
    // Scramble the job bus so only the registered operands can be used.
    bus.JobA = 8'($urandom);
    bus.JobB = 8'($urandom);
  endtask

  // Waits for ResValid and scores the result and the microprocessor activity.
  task automatic wait_result(input int a, input int b, input int exp_d, input int exp_e,
                             input int exp_lat, input bit exp_tout);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      if (bus.ResValid) seen = 1'b1;
      else step();
    end
    chk("res_valid_seen", seen, 1);
    chk("latency", cyc - acc_cyc, exp_lat);
    chk("res_data", bus.ResData, exp_d);
    chk("res_err", bus.ResErr, exp_e);
    chk("busy_in_result", bus.Busy, 1);
    chk("up_reset_at_result", bus.UpReset, exp_tout);
    if (a == 0 || b == 0) begin
      chk("enter_pulses_zero_job", n_rise - base_rise, 0);
    end else begin
      chk("enter_pulses", n_rise - base_rise, 2);
      chk("op_a", op_log[base_rise], a);
      chk("op_b", op_log[base_rise+1], b);
      chk("enter_width_a", width_log[base_rise], ENTER_CYC);
      chk("enter_width_b", width_log[base_rise+1], ENTER_CYC);
    end
  endtask

  // Holds ResReady low for hold cycles, then completes the result handshake.
  task automatic release_result(input int hold, input int exp_d);
    for (int i = 0; i < hold; i++) begin
      bus.ResReady = 1'b0;
      step();
      chk("res_held_valid", bus.ResValid, 1);
      chk("res_held_data", bus.ResData, exp_d);
      chk("job_ready_in_result", bus.JobReady, 0);
    end
    bus.ResReady = 1'b1;
    step();
    bus.ResReady = 1'b0;
    chk("res_valid_cleared", bus.ResValid, 0);
    chk("busy_cleared", bus.Busy, 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_job_ready", bus.JobReady, 0);
    chk("rst_up_reset", bus.UpReset, 1);
    chk("rst_up_enter", bus.UpEnter, 0);
    chk("rst_up_input", bus.UpInput, 0);
    chk("rst_res_valid", bus.ResValid, 0);
    chk("rst_res_data", bus.ResData, 0);
    chk("rst_res_err", bus.ResErr, 0);
    chk("rst_busy", bus.Busy, 0);
  endtask

  typedef struct {
    int a;
    int b;
    int delay;
    int nohalt;
    int exp_d;
    int exp_e;
    int exp_lat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int w;
    int a, b, d, hold, ed, ee;
    bit seen;

    tbl[0] = '{36, 24, 0, 0, 12, 0, 31};
    tbl[1] = '{0, 5, 0, 0, 0, 1, 0};
    tbl[2] = '{5, 0, 0, 0, 0, 1, 0};
    tbl[3] = '{255, 255, 2, 0, 255, 0, 33};
    tbl[4] = '{1, 200, 1, 0, 1, 0, 32};
    tbl[5] = '{128, 96, 4, 0, 32, 0, 35};
    tbl[6] = '{7, 3, 0, 1, 0, 1, 4125};

    RESET_N = 1'b0;
    bus.JobValid = 1'b0;
    bus.JobA = 8'd0;
    bus.JobB = 8'd0;
    bus.ResReady = 1'b0;
    repeat (3) step();
    check_reset_vals();
    RESET_N = 1'b1;
    step();
    chk("post_rst_job_ready", bus.JobReady, 1);
    chk("post_rst_up_reset", bus.UpReset, 0);

    // Fixed job table
    foreach (tbl[i]) begin
      halt_delay = tbl[i].delay;
      halt_off = tbl[i].nohalt[0];
      send_job(8'(tbl[i].a), 8'(tbl[i].b), w);
      wait_result(tbl[i].a, tbl[i].b, tbl[i].exp_d, tbl[i].exp_e, tbl[i].exp_lat,
                  tbl[i].nohalt[0]);
      release_result(1, tbl[i].exp_d);
    end
    halt_off = 1'b0;

    // Result held 20 cycles with a second job pending
    halt_delay = 0;
    send_job(8'd36, 8'd24, w);
    wait_result(36, 24, 12, 0, 31, 1'b0);
    bus.JobValid = 1'b1;
    bus.JobA = 8'd100;
    bus.JobB = 8'd75;
    release_result(20, 12);
    send_job(8'd100, 8'd75, w);
    chk("pending_accept_wait", w, 1);
    wait_result(100, 75, 25, 0, 31, 1'b0);
    release_result(0, 25);

    // Reset during GAP aborts the job without a result
    send_job(8'd9, 8'd6, w);
    repeat (1 + SETUP_CYC + ENTER_CYC + 3) step();
    RESET_N = 1'b0;
    repeat (2) step();
    check_reset_vals();
    RESET_N = 1'b1;
    step();
    chk("abort_job_ready", bus.JobReady, 1);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.ResValid) seen = 1'b1;
      step();
    end
    chk("abort_no_result", seen, 0);
    halt_delay = 1;
    send_job(8'd9, 8'd6, w);
    wait_result(9, 6, 3, 0, 32, 1'b0);
    release_result(0, 3);

    // Stale UpHalt during setup is ignored
    stale_halt = 1'b1;
    step();
    halt_delay = 2;
    send_job(8'd48, 8'd18, w);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (bus.UpEnter) seen = 1'b1;
      else step();
    end
    chk("stale_reached_enter", seen, 1);
    stale_halt = 1'b0;
    wait_result(48, 18, 6, 0, 33, 1'b0);
    release_result(0, 6);

    // Randomized jobs against the reference model
    for (int n = 0; n < 25; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      d = int'($urandom_range(0, 5));
      hold = int'($urandom_range(0, 3));
      halt_delay = d;
      ed = (a == 0 || b == 0) ? 0 : ref_gcd(a, b);
      ee = (a == 0 || b == 0) ? 1 : 0;
      send_job(8'(a), 8'(b), w);
      wait_result(a, b, ed, ee, ref_lat(a, b, d, 1'b0), 1'b0);
      release_result(hold, ed);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
